// File: rtl/mm_slave_pkg.sv
// Shared decode constants, decode result type and stream word layout for the MM write-FIFO slave.
package mm_slave_pkg;

    localparam logic [7:0] CLR_ADDR      = 8'hFF;
    localparam logic [7:0] STAT_CNT_ADDR = 8'hFE;
    localparam logic [7:0] STAT_IGN_ADDR = 8'hFD;

    localparam int MM_ADDR_W = 8;
    localparam int MM_DATA_W = 8;

    typedef enum logic [2:0] {
        DEC_PUSH,
        DEC_CLR,
        DEC_SCNT,
        DEC_SIGN,
        DEC_IGN
    } dec_e;

    typedef struct packed {
        logic [MM_ADDR_W-1:0] addr;
        logic [MM_DATA_W-1:0] data;
    } mm_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: dout shows the head straight from storage, 1-cycle write-to-visible.
// Pushes while full and pops while empty are dropped; clr empties the queue at the next edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mm_wr_fifo_slave.sv
// MM slave queuing in-window writes as {address, data} on a valid/ready stream; 1-cycle write-to-valid, 1-cycle reads.
// waitrequest stalls only in-window writes while the queue is full; reads and control writes never stall.
module mm_wr_fifo_slave
    import mm_slave_pkg::*;
#(
    parameter int              ADDR_W = 8,
    parameter int              DATA_W = 8,
    parameter int              DEPTH  = 16,
    parameter logic [ADDR_W-1:0] SPAN = ADDR_W'(8'h80)
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    input  logic                     read,
    output logic                     waitrequest,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    output logic [ADDR_W+DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    dec_e              dec;
    logic              wr_push;
    logic              wr_clr;
    logic              wr_ign;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [7:0]        ign_cnt;
    logic [DATA_W-1:0] rd_nxt;

    // Control addresses take priority over the push window.
    always_comb begin
        dec = DEC_IGN;
        if (address == ADDR_W'(CLR_ADDR))           dec = DEC_CLR;
        else if (address == ADDR_W'(STAT_CNT_ADDR)) dec = DEC_SCNT;
        else if (address == ADDR_W'(STAT_IGN_ADDR)) dec = DEC_SIGN;
        else if (address < SPAN)                    dec = DEC_PUSH;
    end

    assign wr_push     = write && (dec == DEC_PUSH);
    assign wr_clr      = write && (dec == DEC_CLR);
    assign wr_ign      = write && (dec == DEC_SCNT || dec == DEC_SIGN || dec == DEC_IGN);
    assign waitrequest = wr_push && full;
    assign out_valid   = !empty;

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (wr_push && !full),
        .pop   (out_valid && out_ready),
        .clr   (wr_clr),
        .din   ({address, writedata}),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        rd_nxt = '0;
        case (dec)
            DEC_SCNT: rd_nxt = DATA_W'(count);
            DEC_SIGN: rd_nxt = DATA_W'(ign_cnt);
            default:  rd_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ign_cnt       <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            if (wr_ign && ign_cnt != 8'hFF) ign_cnt <= ign_cnt + 8'd1;
            readdatavalid <= read;
            readdata      <= read ? rd_nxt : '0;
        end
    end

endmodule

// File: tb/tb_mm_wr_fifo_slave.sv
// Directed self-checking bench for mm_wr_fifo_slave with a small queue model for the wrap-around run.
module tb_mm_wr_fifo_slave;
    import mm_slave_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic        write;
    logic [7:0]  writedata;
    logic        read;
    logic        waitrequest;
    logic [7:0]  readdata;
    logic        readdatavalid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    mm_word_t q[$];
    int pushed;
    int pops;

    always #5 CLK = ~CLK;

    mm_wr_fifo_slave dut (
        .CLK           (CLK),
        .reset         (reset),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [7:0] a);
        write   = 1'b0;
        read    = 1'b1;
        address = a;
        tick();
        read    = 1'b0;
    endtask

    initial begin
        reset = 1'b0; address = '0; write = 1'b0; writedata = '0; read = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_rdv", readdatavalid, 0);
        chk("rst_rdata", readdata, 0);
        chk("rst_wait", waitrequest, 0);
        tick();
        reset = 1'b1;
        tick();

        // Every-other-cycle master pattern with the sink always ready.
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            write = 1'b1; address = 8'(n); writedata = 8'(n);
            #1;
            chk("pat_wait", waitrequest, 0);
            tick();
            write = 1'b0;
            chk("pat_valid", out_valid, 1);
            chk("pat_data", out_data, {8'(n), 8'(n)});
            tick();
            chk("pat_drain", out_valid, 0);
        end

        // Fill to full, then stall the 17th write across a pop.
        out_ready = 1'b0;
        write = 1'b1; address = 8'h05;
        for (int i = 0; i < 16; i++) begin
            writedata = 8'(i);
            #1;
            chk("fill_wait", waitrequest, 0);
            tick();
        end
        writedata = 8'hAA;
        #1;
        chk("full_wait", waitrequest, 1);
        tick();
        out_ready = 1'b1;
        #1;
        chk("full_pop_wait", waitrequest, 1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("stall_release", waitrequest, 0);
        tick();
        rd(STAT_CNT_ADDR);
        chk("full_cnt_rdv", readdatavalid, 1);
        chk("full_cnt", readdata, 8'h10);
        chk("full_head", out_data, 16'h0501);

        // Flush, refill five, flush again with a concurrent pop.
        write = 1'b1; address = CLR_ADDR;
        tick();
        write = 1'b0;
        chk("clr1_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            write = 1'b1; address = 8'h10; writedata = 8'(8'h20 + i);
            tick();
        end
        out_ready = 1'b1; address = CLR_ADDR;
        #1;
        chk("clr_head", out_data, 16'h1020);
        tick();
        write = 1'b0; out_ready = 1'b0;
        chk("clr2_valid", out_valid, 0);
        rd(STAT_CNT_ADDR);
        chk("clr_cnt_rdv", readdatavalid, 1);
        chk("clr_cnt", readdata, 0);
        tick();
        chk("rdv_drop", readdatavalid, 0);
        rd(STAT_IGN_ADDR);
        chk("ign_zero", readdata, 0);

        // Out-of-window writes are counted and saturate.
        write = 1'b1; address = 8'h99; writedata = 8'h77;
        for (int i = 0; i < 300; i++) tick();
        write = 1'b0;
        chk("ign_empty", out_valid, 0);
        chk("ign_wait", waitrequest, 0);
        rd(STAT_IGN_ADDR);
        chk("ign_sat", readdata, 8'hFF);
        rd(8'h99);
        chk("idle_rdv", readdatavalid, 1);
        chk("idle_rdata", readdata, 0);

        // Steady push+pop at one word deep.
        write = 1'b1; address = 8'h30; writedata = 8'h00;
        tick();
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            writedata = 8'(k);
            #1;
            chk("pp_valid", out_valid, 1);
            chk("pp_data", out_data, {8'h30, 8'(k - 1)});
            tick();
        end
        out_ready = 1'b0;
        rd(STAT_CNT_ADDR);
        chk("pp_cnt", readdata, 1);
        chk("pp_head", out_data, 16'h300A);
        #1;
        chk("pre_rst_valid", out_valid, 1);
        #1 reset = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_rdv", readdatavalid, 0);
        @(posedge CLK);
        #1 reset = 1'b1;
        rd(STAT_CNT_ADDR);
        chk("post_rst_cnt", readdata, 0);
        rd(STAT_IGN_ADDR);
        chk("post_rst_ign", readdata, 0);

        // 40 words through the 16-deep queue with a bursty sink.
        pushed = 0; pops = 0;
        for (int c = 0; c < 300 && (pushed < 40 || q.size() > 0); c++) begin
            write     = (pushed < 40);
            address   = 8'(pushed);
            writedata = 8'(pushed) ^ 8'h5A;
            out_ready = (c % 3 != 0) || (pushed >= 40);
            #1;
            chk("wrap_valid", out_valid, (q.size() != 0));
            if (out_valid && out_ready && q.size() > 0) begin
                chk("wrap_data", out_data, q[0]);
                void'(q.pop_front());
                pops++;
            end
            if (write && !waitrequest) begin
                q.push_back({address, writedata});
                pushed++;
            end
            tick();
        end
        write = 1'b0; out_ready = 1'b0;
        chk("wrap_pushes", pushed, 40);
        chk("wrap_pops", pops, 40);
        chk("wrap_empty", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
